snn_step_scheduler: RTL and testbench
=====================================

SNN_STEP_SCHEDULER -- requirements
Module: snn_step_scheduler

Interface
REQ-001 SHALL provide parameter STEP_W, default 8, width of the timestep count.
REQ-002 SHALL provide parameter DECAY_CYC, default 4, number of cycles spent in DECAY per timestep.
REQ-003 SHALL provide parameter PDE_CYC, default 2, number of cycles spent in PDE per timestep.
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 255, maximum SYN_ACCU dwell in cycles when the watchdog is compiled in.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-008 SHALL have port num_steps  input  STEP_W  timesteps to run, captured when start is accepted.
REQ-009 SHALL have port accu_fin  input  1  decoder indication that synaptic accumulation is complete.
REQ-010 SHALL have port ack  input  1  host acknowledge of DONE.
REQ-011 SHALL have port state  output  3  state code driven to controller, decoder and group arrangement.
REQ-012 SHALL have port step_cnt  output  STEP_W  completed timesteps in the current or last run.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-014 SHALL have port step_pulse  output  1  one-cycle pulse per completed timestep.
REQ-015 SHALL have port timeout  output  1  sticky watchdog flag.

Function
REQ-016 SHALL encode states IDLE=000, SET=001, SYN_ACCU=010, DECAY=011, PDE=100, FINISH=101, DONE=110; code 111 SHALL never be driven, and SHALL return to IDLE next cycle if reached.
REQ-017 SHALL drive all outputs from registers; state output equals the FSM state register with zero added latency.
REQ-018 IDLE: start=1 with num_steps!=0 SHALL latch num_steps, clear step_cnt, and enter SET next cycle; start with num_steps=0 SHALL be ignored.
REQ-019 SET SHALL last exactly one cycle, then enter SYN_ACCU.
REQ-020 SYN_ACCU SHALL hold until accu_fin=1 is sampled, then enter DECAY next cycle; accu_fin in any other state SHALL be ignored.
REQ-021 DECAY SHALL last exactly DECAY_CYC cycles, then enter PDE; PDE SHALL last exactly PDE_CYC cycles, then enter FINISH; a dwell counter, cleared on each state entry, SHALL time both.
REQ-022 FINISH SHALL last one cycle, assert step_pulse, and increment step_cnt; next state SHALL be DONE if the incremented count equals the latched num_steps, else SET.
REQ-023 DONE SHALL hold with step_cnt retained until ack=1, then enter IDLE; if start and ack are both high in DONE, ack SHALL win and start SHALL be ignored that cycle.
REQ-024 start while not in IDLE SHALL be ignored; num_steps changes after acceptance SHALL have no effect.
REQ-025 step_cnt SHALL never wrap within a run; num_steps=2^STEP_W-1 SHALL complete normally.

Reset
REQ-026 rst=0 at a clock edge SHALL force state=IDLE, step_cnt=0, busy=0, step_pulse=0, timeout=0, and the dwell and latch registers to 0, regardless of current state, including mid-run.
REQ-027 The first start after reset release SHALL be accepted if sampled while rst=1.

Configuration
REQ-028 Macro SNN_STEP_TIMEOUT_EN SHALL compile in the SYN_ACCU watchdog.
REQ-029 With SNN_STEP_TIMEOUT_EN: after TIMEOUT_CYC cycles in SYN_ACCU without accu_fin, the block SHALL enter DECAY, set timeout=1, and keep it set until the next accepted start or reset.
REQ-030 Without SNN_STEP_TIMEOUT_EN: SYN_ACCU SHALL wait indefinitely; timeout SHALL be tied to 0; the port SHALL remain present.

Verification
REQ-031 SHALL verify: num_steps=3, start pulse, accu_fin 5 cycles after each SYN_ACCU entry -> three SET..FINISH sequences, each with DECAY 4 and PDE 2 cycles, three step_pulses, step_cnt=3, and DONE held until ack, then IDLE.
REQ-032 SHALL verify: start with num_steps=0 -> state remains IDLE and busy=0.
REQ-033 SHALL verify: rst=0 asserted during DECAY of step 2 -> next cycle state=IDLE and all outputs 0; a new start with num_steps=1 then runs to DONE with step_cnt=1.
REQ-034 SHALL verify: start and ack both high in DONE -> IDLE next cycle and no new run starts; start pulses during SYN_ACCU are ignored.
REQ-035 SHALL verify, with SNN_STEP_TIMEOUT_EN and TIMEOUT_CYC=10: accu_fin held at 0 -> DECAY entered after 10 SYN_ACCU cycles, timeout=1 through DONE, and timeout cleared on the next accepted start.
REQ-036 SHALL verify, without SNN_STEP_TIMEOUT_EN: accu_fin held at 0 for 1000 cycles -> state stays SYN_ACCU and timeout=0.

Source files
------------

// File: rtl/snn_step_scheduler_if.sv
// snn_step_scheduler_if -- host/decoder-facing signals of the SNN timestep
// scheduler.
//   master : drives start, num_steps, accu_fin, ack; observes status
//   slave  : the scheduler itself
//   start      run request (honoured only in IDLE)
//   num_steps  timesteps to run, captured on accepted start
//   accu_fin   synaptic accumulation complete
//   ack        host acknowledge of DONE
//   state      3-bit state code
//   step_cnt   completed timesteps in current / last run
//   busy       high except in IDLE and DONE
//   step_pulse one-cycle pulse per completed timestep
//   timeout    sticky SYN_ACCU watchdog flag
interface snn_step_scheduler_if #(
   parameter int STEP_W = 8
);
   logic              start;
   logic [STEP_W-1:0] num_steps;
   logic              accu_fin;
   logic              ack;
   logic [2:0]        state;
   logic [STEP_W-1:0] step_cnt;
   logic              busy;
   logic              step_pulse;
   logic              timeout;

   modport master (
      output start, num_steps, accu_fin, ack,
      input  state, step_cnt, busy, step_pulse, timeout
   );

   modport slave (
      input  start, num_steps, accu_fin, ack,
      output state, step_cnt, busy, step_pulse, timeout
   );
endinterface

// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler -- sequences each SNN timestep through
// SET -> SYN_ACCU -> DECAY -> PDE -> FINISH, repeats for num_steps timesteps,
// then parks in DONE until the host acknowledges.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : snn_step_scheduler_if.slave (start/num_steps/accu_fin/ack in,
//          state/step_cnt/busy/step_pulse/timeout out)
// Optional feature: define SNN_STEP_TIMEOUT_EN to compile in the SYN_ACCU
// watchdog (TIMEOUT_CYC cycles). Without it SYN_ACCU waits forever and
// timeout is tied low.
// All outputs come straight from registers; state is the FSM register itself.
module snn_step_scheduler #(
   parameter int STEP_W      = 8,
   parameter int DECAY_CYC   = 4,
   parameter int PDE_CYC     = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input logic                 clk,
   input logic                 rst,
   snn_step_scheduler_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE     = 3'b000,
      S_SET      = 3'b001,
      S_SYN_ACCU = 3'b010,
      S_DECAY    = 3'b011,
      S_PDE      = 3'b100,
      S_FINISH   = 3'b101,
      S_DONE     = 3'b110
   } state_t;

   // dwell counter must reach the largest of the timed intervals
   localparam int DW_MAX0 = (DECAY_CYC > PDE_CYC) ? DECAY_CYC : PDE_CYC;
   localparam int DW_MAX  = (DW_MAX0 > TIMEOUT_CYC) ? DW_MAX0 : TIMEOUT_CYC;
   localparam int DW_W    = $clog2(DW_MAX + 1);

   state_t            state_q, state_d;
   logic [DW_W-1:0]   dwell_q;
   logic [STEP_W-1:0] num_q, cnt_q;
   logic [STEP_W:0]   cnt_inc;
   logic              busy_q, pulse_q;
   logic              accept;
   logic              dwell_run;

   // extra bit so the terminal-count compare can never alias on wrap
   assign cnt_inc = {1'b0, cnt_q} + (STEP_W+1)'(1);

`ifdef SNN_STEP_TIMEOUT_EN
   logic to_q, to_fire;
`endif

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      dwell_run = 1'b0;
`ifdef SNN_STEP_TIMEOUT_EN
      to_fire   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start && (bus.num_steps != '0)) begin
               accept  = 1'b1;
               state_d = S_SET;
            end
         end
         S_SET: state_d = S_SYN_ACCU;
         S_SYN_ACCU: begin
`ifdef SNN_STEP_TIMEOUT_EN
            dwell_run = 1'b1;
            // a real accu_fin on the last allowed cycle is not a timeout
            if (bus.accu_fin)
               state_d = S_DECAY;
            else if (dwell_q == DW_W'(TIMEOUT_CYC - 1)) begin
               state_d = S_DECAY;
               to_fire = 1'b1;
            end
`else
            if (bus.accu_fin) state_d = S_DECAY;
`endif
         end
         S_DECAY: begin
            dwell_run = 1'b1;
            if (dwell_q == DW_W'(DECAY_CYC - 1)) state_d = S_PDE;
         end
         S_PDE: begin
            dwell_run = 1'b1;
            if (dwell_q == DW_W'(PDE_CYC - 1)) state_d = S_FINISH;
         end
         S_FINISH: state_d = (cnt_inc == {1'b0, num_q}) ? S_DONE : S_SET;
         S_DONE: begin
            // start is never looked at here, so ack always wins
            if (bus.ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;   // unused code 3'b111 recovers
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         dwell_q <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) dwell_q <= '0;
         else if (dwell_run)     dwell_q <= dwell_q + DW_W'(1);
         busy_q  <= !((state_d == S_IDLE) || (state_d == S_DONE));
         pulse_q <= (state_d == S_FINISH);
         if (accept) begin
            num_q <= bus.num_steps;
            cnt_q <= '0;
         end else if (state_q == S_FINISH) begin
            cnt_q <= cnt_inc[STEP_W-1:0];
         end
      end
   end

`ifdef SNN_STEP_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst)         to_q <= 1'b0;
      else if (accept)  to_q <= 1'b0;
      else if (to_fire) to_q <= 1'b1;
   end
   assign bus.timeout = to_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.state      = state_q;
   assign bus.step_cnt   = cnt_q;
   assign bus.busy       = busy_q;
   assign bus.step_pulse = pulse_q;
endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb_snn_step_scheduler -- scoreboard bench for snn_step_scheduler.
// Each run is described as timestep segments (SET, SYN_ACCU for d cycles,
// DECAY, PDE, FINISH, DONE); the builder emits one stimulus and one expected
// observation per clock into paired queues. A driver applies stimulus, a
// monitor pops and compares after every clock edge. Inputs that the DUT must
// ignore in a given state are randomised.
module tb_snn_step_scheduler;
   localparam int STEP_W      = 8;
   localparam int DECAY_CYC   = 4;
   localparam int PDE_CYC     = 2;
   localparam int TIMEOUT_CYC = 10;

   localparam logic [2:0] IDLE = 3'd0, SET = 3'd1, SA = 3'd2, DEC = 3'd3,
                          PDE = 3'd4, FIN = 3'd5, DONE = 3'd6;

   logic clk = 1'b0;
   logic rst;

   snn_step_scheduler_if #(.STEP_W(STEP_W)) bus ();

   snn_step_scheduler #(
      .STEP_W(STEP_W), .DECAY_CYC(DECAY_CYC),
      .PDE_CYC(PDE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, start;
      logic [STEP_W-1:0] num;
      logic fin, ack;
   } stim_t;

   typedef struct {
      logic [2:0] st;
      logic [STEP_W-1:0] cnt;
      logic busy, pulse, to;
   } exp_t;

   stim_t stim_q[$];
   exp_t  exp_q[$];
   int    m_cnt;
   bit    m_to;
   int    vectors;
   int    errors;
   bit    built;

   function automatic stim_t rs();
      stim_t s;
      s.rst   = 1'b1;
      s.start = 1'($urandom);
      s.num   = STEP_W'($urandom);
      s.fin   = 1'($urandom);
      s.ack   = 1'($urandom);
      return s;
   endfunction

   task automatic push(input stim_t s, input logic [2:0] st, input logic pulse);
      exp_t e;
      e.st    = st;
      e.cnt   = STEP_W'(m_cnt);
      e.busy  = !(st == IDLE || st == DONE);
      e.pulse = pulse;
      e.to    = m_to;
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // fixed_d=0 -> random accu_fin delay; hang_step/abort_step=0 -> none
   task automatic run(input int n, input int fixed_d, input int hang_step,
                      input int abort_step, input int ack_wait, input bit ack_start);
      stim_t s;
      int d;
      s = rs(); s.start = 1'b1; s.num = STEP_W'(n);
      m_cnt = 0; m_to = 1'b0;
      push(s, SET, 1'b0);
      for (int k = 1; k <= n; k++) begin
         if (k > 1) push(rs(), SET, 1'b0);
         d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 7));
`ifdef SNN_STEP_TIMEOUT_EN
         if (k == hang_step) d = TIMEOUT_CYC;
`else
         if (k == hang_step) d = 1000;
`endif
         for (int j = 0; j < d; j++) begin
            s = rs();
            if (j > 0) s.fin = 1'b0;
            push(s, SA, 1'b0);
         end
         s = rs();
         s.fin = 1'b1;
`ifdef SNN_STEP_TIMEOUT_EN
         if (k == hang_step) begin
            s.fin = 1'b0;
            m_to  = 1'b1;
         end
`endif
         push(s, DEC, 1'b0);
         for (int j = 1; j < DECAY_CYC; j++) begin
            s = rs();
            if (k == abort_step && j == 1) begin
               s.rst = 1'b0;
               m_cnt = 0; m_to = 1'b0;
               push(s, IDLE, 1'b0);
               return;
            end
            push(s, DEC, 1'b0);
         end
         for (int j = 0; j < PDE_CYC; j++) push(rs(), PDE, 1'b0);
         push(rs(), FIN, 1'b1);
         m_cnt++;
      end
      push(rs(), DONE, 1'b0);
      for (int w = 0; w < ack_wait; w++) begin
         s = rs(); s.ack = 1'b0;
         push(s, DONE, 1'b0);
      end
      s = rs(); s.ack = 1'b1;
      if (ack_start) begin
         s.start = 1'b1;
         s.num   = STEP_W'($urandom_range(1, 255));
      end
      push(s, IDLE, 1'b0);
      s = rs(); s.start = 1'b0;
      push(s, IDLE, 1'b0);
   endtask

   // driver
   initial begin
      stim_t s;
      wait (built);
      forever begin
         if (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst = s.rst; bus.start = s.start; bus.num_steps = s.num;
            bus.accu_fin = s.fin; bus.ack = s.ack;
         end else begin
            rst = 1'b1; bus.start = 1'b0; bus.accu_fin = 1'b0; bus.ack = 1'b0;
         end
         @(posedge clk);
         #2;
      end
   end

   // monitor / scoreboard
   initial begin
      exp_t e;
      wait (built);
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({bus.state, bus.step_cnt, bus.busy, bus.step_pulse, bus.timeout} !==
                {e.st, e.cnt, e.busy, e.pulse, e.to}) begin
               errors++;
               $display("FAIL vec%0d: got state=%0d cnt=%0d busy=%b pulse=%b to=%b, want state=%0d cnt=%0d busy=%b pulse=%b to=%b",
                        vectors, bus.state, bus.step_cnt, bus.busy, bus.step_pulse, bus.timeout,
                        e.st, e.cnt, e.busy, e.pulse, e.to);
            end
         end
      end
   end

   initial begin
      stim_t s;
      int total;
      rst = 1'b0; bus.start = 1'b0; bus.num_steps = '0;
      bus.accu_fin = 1'b0; bus.ack = 1'b0;
      vectors = 0; errors = 0; m_cnt = 0; m_to = 1'b0;

      for (int i = 0; i < 3; i++) begin
         s = rs(); s.rst = 1'b0;
         push(s, IDLE, 1'b0);
      end
      run(3, 5, 0, 0, 3, 1'b0);
      for (int i = 0; i < 2; i++) begin
         s = rs(); s.start = 1'b1; s.num = '0;
         push(s, IDLE, 1'b0);
      end
      run(3, 5, 0, 2, 0, 1'b0);
      run(1, 0, 0, 0, 2, 1'b1);
      run(2, 0, 1, 0, 1, 1'b0);
      run(1, 0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++)
         run(int'($urandom_range(1, 4)), 0, 0, 0, int'($urandom_range(0, 3)), 1'($urandom));
      run(255, 1, 0, 0, 0, 1'b0);

      total = exp_q.size();
      built = 1'b1;
      for (int c = 0; c < total + 50 && exp_q.size() > 0; c++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors unchecked, want 0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
